phoenix_injector: RTL and testbench
===================================

# phoenix_injector

Local-port packet transmitter for the Phoenix NoC router. Accepts a packet descriptor (target, payload length) and a payload word stream from the attached core, then serialises it onto the router's input link as header flit, size flit and payload flits. It drives `tx`/`data_out` under credit-based flow control, so it is the sending end of the link that a Phoenix input buffer receives.

## Interface
- `FLIT_W`, default `` `TAM_FLIT ``: flit width in bits.
- `STATS_W`, default 16: width of the packet statistics counter (only used with `PHOENIX_INJ_STATS_EN`).

Ports:
- `clock`  in  1  single clock domain. One clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pkt_valid`  in  1  descriptor offered.
- `pkt_ready`  out  1  descriptor accepted when `pkt_valid & pkt_ready` at an edge.
- `pkt_target`  in  FLIT_W  header flit value (destination address).
- `pkt_size`  in  FLIT_W  number of payload flits. Must be ≥1.
- `pl_valid`  in  1  payload word offered.
- `pl_ready`  out  1  payload word consumed when `pl_valid & pl_ready` at an edge.
- `pl_data`  in  FLIT_W  payload word.
- `clock_tx`  out  1  equal to `clock`. Drives the receiver's `clock_rx`.
- `tx`  out  1  flit present on `data_out`.
- `data_out`  out  FLIT_W  flit.
- `credit_i`  in  1  receiver has space. A flit transfers at an edge where `tx & credit_i`.
- `busy`  out  1  a packet is in progress or a flit is still held.
- `size_err`  out  1  one-cycle pulse: descriptor with `pkt_size==0` was dropped.
- `pkt_count`  out  STATS_W  packets fully transferred (only with `PHOENIX_INJ_STATS_EN`).

## Operation
- FSM states:
  - IDLE: descriptor accepted → SIZE. The header is loaded into the output register on the same edge.
  - SIZE: size flit loaded → PAYLOAD. The remaining-count register is set to `pkt_size`.
  - PAYLOAD: each payload load decrements the remaining count. The load made when the count is 1 → IDLE.
- One-entry output register (`tx`, `data_out`):
  - Free when `tx==0` or `tx & credit_i`.
  - Loads occur only when the register is free.
  - While `tx & !credit_i`, `tx` and `data_out` are held stable.
- `pkt_ready = IDLE & free`.
- `pl_ready = PAYLOAD & free`. This path is combinational from `credit_i`.
- A payload load requires `pl_valid`. If `pl_valid` is low and the register drains, `tx` falls to 0 (bubble allowed).
- Descriptor with `pkt_size==0`:
  - Consumed (`pkt_ready` behaves normally).
  - Nothing is loaded, and the FSM stays in IDLE.
  - `size_err` is high the next cycle.
  - Reason: the receiver's flit counter cannot terminate on size 0.
- Packet length on the link is always `pkt_size + 2` flits, in order: target, size, payloads.
- Target and size are latched at acceptance. Later changes on `pkt_target`/`pkt_size` have no effect.
- `busy = (state != IDLE) | tx`.

## Timing
- Reset values:
  - State IDLE, `tx=0`, `data_out=0`, `size_err=0`, remaining count 0, `pkt_count=0`.
  - `busy=0`; `pkt_ready=1` and `pl_ready=0` in the first cycle after reset.
- Latency:
  - The header appears on `tx` in the cycle after descriptor acceptance.
  - Each payload word appears in the cycle after its `pl` handshake.
- Throughput: with `credit_i` and `pl_valid` held high, one flit per cycle and no gaps.
- Back-to-back packets: the next header can load on the same edge the last payload transfers. No idle cycle between packets.
- Simultaneous transfer and load: the outgoing flit transfers and the new flit is visible the next cycle.
- `credit_i` low: the flit is held and nothing is dropped or duplicated. `pkt_ready` and `pl_ready` are low.
- Reset mid-packet: the packet is abandoned and `tx` is 0 the next cycle. The receiver is reset with the same `reset`.
- Remaining count is FLIT_W wide. `pkt_size` = 2^FLIT_W−1 is legal and sends all payloads.

## Configuration
- `PHOENIX_INJ_STATS_EN` defined:
  - `pkt_count` exists.
  - It increments on the edge where the last payload flit transfers (`tx & credit_i` and the flit is final).
  - It wraps modulo 2^STATS_W.
- Undefined: the `pkt_count` port and counter are absent. All other behaviour is identical.

## Structure
- `defines.vh` supplies `TAM_FLIT`.
- FSM state encodings (IDLE=0, SIZE=1, PAYLOAD=2) go in `defines.vh` as shared localparams/macros.
- One sub-module: `phoenix_out_reg`, the one-entry output holding register.
  - Inputs: `load`, `d`, `credit_i`.
  - Outputs: `tx`, `data_out`, `free`.

## Test plan
- Descriptor target=0x12, size=3, payload 0xA1,0xA2,0xA3, `credit_i=1`, `pl_valid=1` → `data_out` 0x12,0x03,0xA1,0xA2,0xA3 on 5 consecutive cycles starting 1 cycle after acceptance; then `busy=0`.
- Same packet with `credit_i` low for 4 cycles during the size flit → 0x03 held stable with `tx=1`, `pkt_ready=pl_ready=0`; the sequence resumes unchanged and there are no duplicates.
- Two descriptors back-to-back (size 1 each) → 6 flits in 6 consecutive cycles; `pkt_count=2` with STATS_EN.
- `pkt_size=0` → no `tx`, `size_err` one-cycle pulse, FSM in IDLE, next descriptor sent normally.
- `pl_valid` low for 2 cycles mid-payload → `tx=0` bubble of 2 cycles, remaining count preserved, packet completes with the correct flit count.
- `reset` asserted during the 2nd payload flit of a size-5 packet → `tx=0` and `pkt_ready=1` the next cycle; a fresh packet then transmits intact.

Source files
------------

// File: rtl/phoenix_injector_pkg.sv
// phoenix_injector_pkg: shared FSM state encoding for the Phoenix injector
package phoenix_injector_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SIZE = 2'd1, PAYLOAD = 2'd2} inj_state_t;
endpackage

// File: rtl/phoenix_out_reg.sv
// phoenix_out_reg: one-entry flit holding register driving tx/data_out under credit flow control
module phoenix_out_reg #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         credit_i,
  output logic         tx,
  output logic [W-1:0] data_out,
  output logic         free
);
  assign free = !tx || credit_i;
  // load a new flit, drop tx once the held flit drains, hold while the receiver is full
  always_ff @(posedge clock)
    if (reset) begin
      tx       <= 1'b0;
      data_out <= '0;
    end else if (load) begin
      tx       <= 1'b1;
      data_out <= d;
    end else if (free) tx <= 1'b0;
endmodule

// File: rtl/phoenix_injector.sv
// phoenix_injector: Phoenix NoC local-port packet transmitter; PHOENIX_INJ_STATS_EN adds pkt_count
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif
module phoenix_injector
  import phoenix_injector_pkg::*;
#(
  parameter int FLIT_W = `TAM_FLIT
`ifdef PHOENIX_INJ_STATS_EN
  , parameter int STATS_W = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [FLIT_W-1:0] pkt_target,
  input  logic [FLIT_W-1:0] pkt_size,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [FLIT_W-1:0] pl_data,
  output logic              clock_tx,
  output logic              tx,
  output logic [FLIT_W-1:0] data_out,
  input  logic              credit_i,
  output logic              busy,
  output logic              size_err
`ifdef PHOENIX_INJ_STATS_EN
  , output logic [STATS_W-1:0] pkt_count
`endif
);
  inj_state_t state, next;
  logic [FLIT_W-1:0] size_q, rem, d;
  logic free, load, acc, pl_hs, size_ld;
  assign clock_tx = clock;
  assign busy = state != IDLE || tx;
  phoenix_out_reg #(.W(FLIT_W)) u_out (
    .clock(clock), .reset(reset), .load(load), .d(d), .credit_i(credit_i),
    .tx(tx), .data_out(data_out), .free(free)
  );
  // handshakes, output-register load select and next state
  always_comb begin
    pkt_ready = state == IDLE && free;
    pl_ready  = state == PAYLOAD && free;
    acc       = pkt_valid && pkt_ready;
    pl_hs     = pl_valid && pl_ready;
    size_ld   = state == SIZE && free;
    load      = (acc && pkt_size != '0) || size_ld || pl_hs;
    d         = state == IDLE ? pkt_target : state == SIZE ? size_q : pl_data;
    next      = acc && pkt_size != '0 ? SIZE : size_ld ? PAYLOAD :
                pl_hs && rem == FLIT_W'(1) ? IDLE : state;
  end
  // state, latched size, remaining payload count and zero-size drop pulse
  always_ff @(posedge clock)
    if (reset) begin
      state    <= IDLE;
      size_q   <= '0;
      rem      <= '0;
      size_err <= 1'b0;
    end else begin
      state    <= next;
      size_err <= acc && pkt_size == '0;
      if (acc) size_q <= pkt_size;
      if (size_ld) rem <= size_q;
      else if (pl_hs) rem <= rem - FLIT_W'(1);
    end
`ifdef PHOENIX_INJ_STATS_EN
  logic last_q;
  // mark the held flit as a packet's last payload and count it when it transfers
  always_ff @(posedge clock)
    if (reset) begin
      last_q    <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (load) last_q <= pl_hs && rem == FLIT_W'(1);
      else if (free) last_q <= 1'b0;
      if (tx && credit_i && last_q) pkt_count <= pkt_count + STATS_W'(1);
    end
`endif
endmodule

// File: tb/tb_phoenix_injector.sv
// tb_phoenix_injector: vector table plus scoreboarded packet sequences for phoenix_injector
module tb_phoenix_injector;
  localparam int W = 16;
  typedef struct {
    logic         pv;
    logic [W-1:0] sz;
    logic         plv;
    logic [W-1:0] pld;
    logic         cr;
    logic [19:0]  exp;
  } vec_t;
  logic clock = 0, reset = 1, pkt_valid = 0, pl_valid = 0, credit_i = 1;
  logic [W-1:0] pkt_target = 0, pkt_size = 0, pl_data = 0;
  logic pkt_ready, pl_ready, clock_tx, tx, busy, size_err;
  logic [W-1:0] data_out;
`ifdef PHOENIX_INJ_STATS_EN
  logic [15:0] pkt_count, cnt0;
`endif
  int n_chk = 0, n_fail = 0, cyc_n = 0, first_c = -1, last_c = -1, bub = 0;
  logic hs_pkt = 0, hs_pl = 0, sb_on = 0;
  logic [W-1:0] exp_q[$];
  vec_t vt[$];
  always #5 clock = ~clock;
  phoenix_injector #(.FLIT_W(W)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_target(pkt_target), .pkt_size(pkt_size), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .pl_data(pl_data), .clock_tx(clock_tx), .tx(tx), .data_out(data_out),
    .credit_i(credit_i), .busy(busy), .size_err(size_err)
`ifdef PHOENIX_INJ_STATS_EN
    , .pkt_count(pkt_count)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL timeout %s: no handshake within 50 cycles", nm);
  endtask
  task automatic cyc();
    #1;
    hs_pkt = pkt_valid && pkt_ready;
    hs_pl = pl_valid && pl_ready;
    if (sb_on && busy && !tx) bub++;
    if (sb_on && tx && credit_i) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL flit: got unexpected %0h expected none", data_out);
      end else chk("flit", data_out, exp_q.pop_front());
      if (first_c < 0) first_c = cyc_n;
      last_c = cyc_n;
    end
    cyc_n++;
    @(negedge clock);
  endtask
  task automatic send(input logic [W-1:0] tgt, input logic [W-1:0] sz, input logic [W-1:0] base, input int gap_at);
    int lim;
    exp_q.push_back(tgt);
    exp_q.push_back(sz);
    for (int k = 0; k < int'(sz); k++) exp_q.push_back(base + W'(k));
    pkt_valid = 1;
    pkt_target = tgt;
    pkt_size = sz;
    lim = 0;
    do begin cyc(); lim++; end while (!hs_pkt && lim < 50);
    if (!hs_pkt) timeout("pkt_accept");
    pkt_valid = 0;
    pkt_target = '1;
    pkt_size = '1;
    for (int k = 0; k < int'(sz); k++) begin
      if (k == gap_at) begin
        pl_valid = 0;
        cyc();
        cyc();
      end
      pl_valid = 1;
      pl_data = base + W'(k);
      lim = 0;
      do begin cyc(); lim++; end while (!hs_pl && lim < 50);
      if (!hs_pl) timeout("pl_accept");
    end
    pl_valid = 0;
  endtask
  task automatic drain();
    int lim = 0;
    while (busy && lim < 50) begin cyc(); lim++; end
    if (busy) timeout("drain");
    chk("queue_empty", exp_q.size(), 0);
  endtask
  function automatic vec_t v(logic pv, logic [W-1:0] sz, logic plv, logic [W-1:0] pld, logic cr,
                             logic etx, logic eprdy, logic eplrdy, logic ebusy, logic [W-1:0] dout);
    vec_t r;
    r.pv = pv; r.sz = sz; r.plv = plv; r.pld = pld; r.cr = cr;
    r.exp = {etx, eprdy, eplrdy, ebusy, dout};
    return r;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lim;
    // basic packet: 0x12, size 3, payload A1..A3
    vt.push_back(v(1, 3, 0, 16'h00, 1, 0, 1, 0, 0, 16'h00));
    vt.push_back(v(0, 3, 1, 16'hA1, 1, 1, 0, 0, 1, 16'h12));
    vt.push_back(v(0, 3, 1, 16'hA1, 1, 1, 0, 1, 1, 16'h03));
    vt.push_back(v(0, 3, 1, 16'hA2, 1, 1, 0, 1, 1, 16'hA1));
    vt.push_back(v(0, 3, 1, 16'hA3, 1, 1, 0, 1, 1, 16'hA2));
    vt.push_back(v(0, 3, 0, 16'h00, 1, 1, 1, 0, 1, 16'hA3));
    vt.push_back(v(0, 3, 0, 16'h00, 1, 0, 1, 0, 0, 16'hA3));
    // same packet with credit low 4 cycles on the size flit; pkt_size changed after accept
    vt.push_back(v(1, 3, 0, 16'h00, 1, 0, 1, 0, 0, 16'hA3));
    vt.push_back(v(0, 7, 1, 16'hA1, 1, 1, 0, 0, 1, 16'h12));
    for (int i = 0; i < 4; i++) vt.push_back(v(0, 7, 1, 16'hA1, 0, 1, 0, 0, 1, 16'h03));
    vt.push_back(v(0, 7, 1, 16'hA1, 1, 1, 0, 1, 1, 16'h03));
    vt.push_back(v(0, 7, 1, 16'hA2, 1, 1, 0, 1, 1, 16'hA1));
    vt.push_back(v(0, 7, 1, 16'hA3, 1, 1, 0, 1, 1, 16'hA2));
    vt.push_back(v(0, 7, 0, 16'h00, 1, 1, 1, 0, 1, 16'hA3));
    vt.push_back(v(0, 7, 0, 16'h00, 1, 0, 1, 0, 0, 16'hA3));
    repeat (2) @(negedge clock);
    reset = 0;
    #1;
    chk("rst_tx", tx, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_ready", pkt_ready, 1);
    chk("rst_pl_ready", pl_ready, 0);
    chk("rst_size_err", size_err, 0);
`ifdef PHOENIX_INJ_STATS_EN
    chk("rst_pkt_count", pkt_count, 0);
`endif
    @(posedge clock);
    #1;
    chk("clock_tx", clock_tx, clock);
    @(negedge clock);
    pkt_target = 16'h12;
    foreach (vt[i]) begin
      pkt_valid = vt[i].pv;
      pkt_size = vt[i].sz;
      pl_valid = vt[i].plv;
      pl_data = vt[i].pld;
      credit_i = vt[i].cr;
      #1;
      chk($sformatf("vec%0d {tx,prdy,plrdy,busy,data}", i), {tx, pkt_ready, pl_ready, busy, data_out}, vt[i].exp);
      @(negedge clock);
    end
    pkt_valid = 0;
    pl_valid = 0;
    credit_i = 1;
    sb_on = 1;
`ifdef PHOENIX_INJ_STATS_EN
    cnt0 = pkt_count;
`endif
    first_c = -1;
    send(16'h21, 1, 16'h31, -1);
    send(16'h22, 1, 16'h32, -1);
    drain();
    chk("b2b_span", last_c - first_c, 5);
`ifdef PHOENIX_INJ_STATS_EN
    chk("b2b_pkt_count", pkt_count - cnt0, 2);
`endif
    pkt_valid = 1;
    pkt_target = 16'h77;
    pkt_size = 0;
    cyc();
    chk("zero_accepted", hs_pkt, 1);
    pkt_valid = 0;
    #1;
    chk("zero_size_err", size_err, 1);
    chk("zero_tx", tx, 0);
    chk("zero_busy", busy, 0);
    chk("zero_pkt_ready", pkt_ready, 1);
    @(negedge clock);
    #1;
    chk("zero_size_err_pulse", size_err, 0);
    chk("zero_tx_later", tx, 0);
    @(negedge clock);
    send(16'h78, 2, 16'hC0, -1);
    drain();
    bub = 0;
    send(16'h40, 4, 16'hB0, 2);
    drain();
    chk("bubble_cycles", bub, 2);
    sb_on = 0;
    pkt_valid = 1;
    pkt_target = 16'h55;
    pkt_size = 5;
    cyc();
    pkt_valid = 0;
    pl_valid = 1;
    pl_data = 16'hD1;
    lim = 0;
    while (!(tx && data_out == 16'hD2) && lim < 50) begin
      cyc();
      if (hs_pl) pl_data++;
      lim++;
    end
    if (!(tx && data_out == 16'hD2)) timeout("second_payload");
    reset = 1;
    pl_valid = 0;
    cyc();
    reset = 0;
    #1;
    chk("mid_rst_tx", tx, 0);
    chk("mid_rst_pkt_ready", pkt_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pl_ready", pl_ready, 0);
    @(negedge clock);
    sb_on = 1;
    send(16'h56, 2, 16'hE0, -1);
    drain();
`ifdef PHOENIX_INJ_STATS_EN
    chk("post_rst_pkt_count", pkt_count, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
